// File: rtl/rom_port_arbiter.sv
// ============================================================================
//  Module   : rom_port_arbiter
//  Purpose  : Round-robin ROM read-port arbiter with starvation override and
//             an in-order, fixed-latency return path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rom_port_arbiter #(
   parameter int NREQ     = 3,
   parameter int ADDR_W   = 21,
   parameter int DATA_W   = 1,
   parameter int ROM_LAT  = 1,
   parameter int MAX_WAIT = 7
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     en,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*ADDR_W-1:0]   addr,
   output logic [NREQ-1:0]          gnt,
   output logic                     rom_rd,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [DATA_W-1:0]        rom_data,
   output logic [NREQ-1:0]          rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     busy
);

   localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_MIN = $clog2(MAX_WAIT + 1);
   localparam int CNT_W   = (CNT_MIN > 3) ? CNT_MIN : 3;
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

   logic                 ready_q;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [CNT_W-1:0]     wcnt_q [NREQ];
   logic [CNT_W-1:0]     wcnt_d [NREQ];
   logic [ROM_LAT-1:0]   pv_q;
   logic [IDX_W-1:0]     pidx_q [ROM_LAT];
   logic [DATA_W-1:0]    rd_data_q;

   logic                 arb_en;
   logic [NREQ-1:0]      elig;
   logic                 found;
   logic [IDX_W-1:0]     sel_idx;
   int                   cand;

   // ready_q holds off arbitration for the first edge after reset release
   assign arb_en = en & ready_q;
   assign elig   = req & ~gnt_q;

   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      cand    = 0;
      if (arb_en) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && elig[i] && (wcnt_q[i] == WAIT_LIM)) begin
               found   = 1'b1;
               sel_idx = IDX_W'(i);
            end
         end
         for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NREQ) begin
               cand = cand - NREQ;
            end
            if (!found && elig[IDX_W'(cand)]) begin
               found   = 1'b1;
               sel_idx = IDX_W'(cand);
            end
         end
      end
   end

   always_comb begin
      gnt_d      = '0;
      rom_addr_d = rom_addr_q;
      last_d     = last_q;
      if (found) begin
         gnt_d[sel_idx] = 1'b1;
         rom_addr_d     = addr[int'(sel_idx)*ADDR_W +: ADDR_W];
         last_d         = sel_idx;
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         wcnt_d[i] = wcnt_q[i];
         if (arb_en) begin
            if (!req[i] || (found && (sel_idx == IDX_W'(i)))) begin
               wcnt_d[i] = '0;
            end else if (elig[i] && (wcnt_q[i] != WAIT_LIM)) begin
               wcnt_d[i] = wcnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ready_q    <= 1'b0;
         gnt_q      <= '0;
         rom_addr_q <= '0;
         last_q     <= LAST_RST;
         for (int i = 0; i < NREQ; i++) begin
            wcnt_q[i] <= '0;
         end
      end else begin
         ready_q    <= 1'b1;
         gnt_q      <= gnt_d;
         rom_addr_q <= rom_addr_d;
         last_q     <= last_d;
         for (int i = 0; i < NREQ; i++) begin
            wcnt_q[i] <= wcnt_d[i];
         end
      end
   end

   // last_q always names the owner of gnt_q, so it doubles as the issue index
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pv_q      <= '0;
         rd_data_q <= '0;
         for (int j = 0; j < ROM_LAT; j++) begin
            pidx_q[j] <= '0;
         end
      end else begin
         pv_q[0]   <= |gnt_q;
         pidx_q[0] <= last_q;
         for (int j = 1; j < ROM_LAT; j++) begin
            pv_q[j]   <= pv_q[j-1];
            pidx_q[j] <= pidx_q[j-1];
         end
         rd_data_q <= rd_data;
      end
   end

   always_comb begin
      rd_valid = '0;
      if (pv_q[ROM_LAT-1]) begin
         rd_valid[pidx_q[ROM_LAT-1]] = 1'b1;
      end
   end

   assign rd_data  = pv_q[ROM_LAT-1] ? rom_data : rd_data_q;
   assign gnt      = gnt_q;
   assign rom_rd   = |gnt_q;
   assign rom_addr = rom_addr_q;
   assign busy     = (|gnt_q) | (|pv_q);

endmodule

`default_nettype wire

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
- REQ-001 SHALL have parameter NREQ, default 3: requester count (0 = background, 1 = platforms, 2 = doodle sprite).
- REQ-002 SHALL have parameter ADDR_W, default 21: ROM address width.
- REQ-003 SHALL have parameter DATA_W, default 1: ROM data width.
- REQ-004 SHALL have parameter ROM_LAT, default 1, legal 1..3: ROM read latency in clocks.
- REQ-005 SHALL have parameter MAX_WAIT, default 7: starvation limit in cycles.
- REQ-006 Ports:
  - Clk  in  1  the single clock; all logic is on its rising edge.
  - Reset  in  1  asynchronous, active-high.
  - en  in  1  arbitration enable.
  - req  in  NREQ  per-requester read request (level).
  - addr  in  NREQ*ADDR_W  per-requester address; slice i is addr[i*ADDR_W +: ADDR_W].
  - gnt  out  NREQ  one-hot grant (registered).
  - rom_rd  out  1  ROM read strobe.
  - rom_addr  out  ADDR_W  ROM address (registered).
  - rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_addr.
  - rd_valid  out  NREQ  one-hot return strobe.
  - rd_data  out  DATA_W  returned data.
  - busy  out  1  high while any read is in flight.

Function
- REQ-007 Arbitration SHALL be evaluated every cycle in which en=1; at most one grant per cycle.
- REQ-008 Eligible set: req[i]=1 AND gnt[i]=0 in the current cycle (a requester just granted is masked for one cycle).
- REQ-009 Selection SHALL be round-robin, searching from (last_granted+1) mod NREQ upward. last_granted resets to NREQ-1, so requester 0 wins first.
- REQ-010 Starvation override: per-requester wait counter, 3 bits minimum, saturating.
  - Increments each cycle the requester is eligible and not selected; clears on its grant or when its req=0.
  - A requester whose counter equals MAX_WAIT SHALL win over round-robin order.
  - If several requesters are starved, the lowest index wins.
- REQ-011 Issue timing: eligible request sampled at edge N -> at edge N+1 the following hold for exactly one cycle:
  - gnt[i]=1;
  - rom_rd=1;
  - rom_addr = addr slice i as sampled at edge N.
- REQ-012 When nothing is selected: gnt=0, rom_rd=0, and rom_addr SHALL hold its previous value.
- REQ-013 Return path SHALL be a ROM_LAT-deep shift pipeline of {valid, requester index}.
  - rd_valid[i] pulses ROM_LAT cycles after the gnt[i] cycle.
  - rd_data = rom_data in that cycle; rd_data holds its last value otherwise.
- REQ-014 Throughput SHALL be one read per cycle sustained.
  - Back-to-back grants to different requesters are allowed.
  - The same requester can be granted at most every other cycle (REQ-008).
- REQ-015 busy = OR of rom_rd and all pipeline valid bits.
- REQ-016 en=0 SHALL block new grants only; in-flight returns still complete. Wait counters freeze while en=0.
- REQ-017 req dropping before its grant SHALL cancel the request with no grant and no return.
- REQ-018 addr changes while req=1 and ungranted: the value at the selecting edge is used.
- REQ-019 A requester that keeps req=1 after gnt SHALL be treated as a new request from the following cycle.
- REQ-020 Ordering: returns SHALL be in issue order; no reordering.

Reset
- REQ-021 Reset=1 SHALL immediately (asynchronously) force: gnt=0, rom_rd=0, rd_valid=0, busy=0, rom_addr=0, rd_data=0.
- REQ-022 Reset SHALL also clear all pipeline valid bits and wait counters, and set last_granted=NREQ-1.
- REQ-023 Reset mid-operation SHALL discard in-flight reads: no rd_valid after deassertion for reads issued before reset.
- REQ-024 First possible grant SHALL be at the second rising edge after Reset deasserts.

Verification
- V1 Basic issue/return: req=3'b001, addr0=21'd1234, ROM_LAT=1 -> next cycle gnt=001, rom_addr=1234, rom_rd=1; one cycle later rd_valid=001, rd_data=ROM[1234].
- V2 Round-robin: req=3'b111 held for 6 cycles -> grant sequence 0,1,2,0,1,2; rd_valid follows the same order shifted by ROM_LAT.
- V3 Starvation, MAX_WAIT=2:
  - Requesters 0 and 1 toggle req so that they are always eligible ahead of 2; req2 held high.
  - Required: gnt[2] no later than the 3rd cycle after req2 rises.
- V4 Enable gating: grant issued at cycle N, en dropped at N+1.
  - No further gnt while en=0.
  - rd_valid for the cycle-N read still arrives at N+ROM_LAT.
  - busy falls after that return.
- V5 Reset mid-flight: ROM_LAT=3, Reset pulsed 1 cycle after a grant -> no rd_valid ever appears for that read; first new gnt appears 2 edges after Reset falls.
- V6 Cancellation and re-request:
  - req1 pulsed 1 cycle while req0 is being granted -> no gnt[1].
  - req0 held high continuously -> gnt[0] on alternating cycles only.
